// File: rtl/controller_pkg.sv
// Shared types and constants for the controller bus arbiter: arbiter state
// encoding, the default bus-free interval and a round-robin wrap helper.
package controller_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_WAIT_FREE = 2'd1,
      ARB_GRANTED   = 2'd2,
      ARB_RELEASE   = 2'd3
   } arb_state_e;

   // Bus-free interval in clk cycles that integrators start from.
   localparam int unsigned DEFAULT_T_BUS_FREE = 32'd50;

   // Index following idx in a ring of n entries.
   function automatic int rr_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ctrl_rr_pick.sv
// Round-robin winner search: first asserted request at or after ptr_i,
// wrapping modulo NumEngines.
module ctrl_rr_pick #(
   parameter int NumEngines = 2,
   localparam int IdxWidth = $clog2(NumEngines)
) (
   input  logic [NumEngines-1:0] req_i,
   input  logic [IdxWidth-1:0]   ptr_i,
   output logic [IdxWidth-1:0]   idx_o,
   output logic                  valid_o
);

   logic [IdxWidth-1:0] cand;

   // Scan from the farthest candidate back to ptr_i so the nearest request wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = NumEngines - 1; k >= 0; k--) begin
         cand = IdxWidth'((int'(ptr_i) + k) % NumEngines);
         if (req_i[cand]) begin
            idx_o   = cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// Arbitrates several bus controller engines onto one PHY: round-robin pick,
// bus-free wait, exclusive grant with registered PHY drive, one-cycle release.
module ctrl_bus_arbiter
   import controller_pkg::*;
#(
   parameter int NumEngines = 2,
   parameter int TimerWidth = 20,
   localparam int IdxWidth = $clog2(NumEngines)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [NumEngines-1:0] req_i,
   input  logic [NumEngines-1:0] done_i,
   input  logic [NumEngines-1:0] eng_scl_i,
   input  logic [NumEngines-1:0] eng_sda_i,
   input  logic [NumEngines-1:0] eng_sel_od_pp_i,
   input  logic                  bus_scl_i,
   input  logic                  bus_sda_i,
   input  logic [TimerWidth-1:0] t_bus_free_i,
   output logic [NumEngines-1:0] gnt_o,
   output logic                  ctrl_scl_o,
   output logic                  ctrl_sda_o,
   output logic                  phy_sel_od_pp_o,
   output logic [IdxWidth-1:0]   active_idx_o,
   output logic                  busy_o,
   output logic                  abort_o,
   output logic [1:0]            dbg_state_o
);

   // Handshake: req_i is a level held by an engine for as long as it wants
   // the bus; gnt_o answers it exclusively; done_i is a one-cycle release
   // pulse, and dropping req_i while granted is treated as an abort.

   arb_state_e            state_q, state_d;
   logic [IdxWidth-1:0]   ptr_q, ptr_d;
   logic [IdxWidth-1:0]   winner_q, winner_d;
   logic [TimerWidth-1:0] timer_q, timer_d;
   logic [NumEngines-1:0] gnt_q, gnt_d;
   logic                  scl_q, scl_d;
   logic                  sda_q, sda_d;
   logic                  od_pp_q, od_pp_d;
   logic                  busy_q, busy_d;
   logic                  abort_q, abort_d;

   logic [IdxWidth-1:0]   pick_idx;
   logic                  pick_valid;

   ctrl_rr_pick #(
      .NumEngines (NumEngines)
   ) u_rr_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      winner_d = winner_q;
      timer_d  = timer_q;
      abort_d  = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (enable_i && pick_valid) begin
               winner_d = pick_idx;
               timer_d  = '0;
               state_d  = ARB_WAIT_FREE;
            end
         end
         ARB_WAIT_FREE: begin
            // The comparison uses the count before this cycle's update, so
            // a zero interval grants after a single WAIT_FREE cycle.
            if (!req_i[winner_q]) begin
               state_d = ARB_IDLE;
            end else if (timer_q >= t_bus_free_i) begin
               state_d = ARB_GRANTED;
            end
            if (bus_scl_i && bus_sda_i) begin
               if (timer_q != '1) begin
                  timer_d = timer_q + TimerWidth'(1);
               end
            end else begin
               timer_d = '0;
            end
         end
         ARB_GRANTED: begin
            if (done_i[winner_q]) begin
               state_d = ARB_RELEASE;
               ptr_d   = IdxWidth'(rr_inc(int'(winner_q), NumEngines));
            end else if (!req_i[winner_q]) begin
               state_d = ARB_RELEASE;
               abort_d = 1'b1;
               ptr_d   = IdxWidth'(rr_inc(int'(winner_q), NumEngines));
            end
         end
         ARB_RELEASE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state, so they line up with state_q.
   always_comb begin
      gnt_d   = '0;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      od_pp_d = 1'b0;
      busy_d  = (state_d != ARB_IDLE);
      if (state_d == ARB_GRANTED) begin
         gnt_d[winner_q] = 1'b1;
         scl_d           = eng_scl_i[winner_q];
         sda_d           = eng_sda_i[winner_q];
         od_pp_d         = eng_sel_od_pp_i[winner_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= '0;
         winner_q <= '0;
         timer_q  <= '0;
         gnt_q    <= '0;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
         od_pp_q  <= 1'b0;
         busy_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         winner_q <= winner_d;
         timer_q  <= timer_d;
         gnt_q    <= gnt_d;
         scl_q    <= scl_d;
         sda_q    <= sda_d;
         od_pp_q  <= od_pp_d;
         busy_q   <= busy_d;
         abort_q  <= abort_d;
      end
   end

   assign gnt_o           = gnt_q;
   assign ctrl_scl_o      = scl_q;
   assign ctrl_sda_o      = sda_q;
   assign phy_sel_od_pp_o = od_pp_q;
   assign active_idx_o    = winner_q;
   assign busy_o          = busy_q;
   assign abort_o         = abort_q;
   assign dbg_state_o     = state_q;

endmodule

// File: doc/ctrl_bus_arbiter.md
CTRL_BUS_ARBITER -- requirements
Module: ctrl_bus_arbiter

Interface
REQ-001 SHALL have parameter NumEngines, default 2, the number of controller engines (I2C, I3C, ...) sharing one PHY; legal range 2..8.
REQ-002 SHALL have parameter TimerWidth, default 20, the width of the bus-free timer and t_bus_free_i.
REQ-003 SHALL have localparam IdxWidth = $clog2(NumEngines).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i (in, 1, rising-edge clock) and rst_i (in, 1, synchronous active-high reset).
REQ-005 enable_i  in  1  permits new grants.
REQ-006 req_i  in  NumEngines  level request per engine.
REQ-007 done_i  in  NumEngines  single-cycle release pulse per engine.
REQ-008 eng_scl_i / eng_sda_i  in  NumEngines each  per-engine SCL/SDA drive.
REQ-009 eng_sel_od_pp_i  in  NumEngines  per-engine drive mode (0 = open-drain, 1 = push-pull).
REQ-010 bus_scl_i / bus_sda_i  in  1 each  sampled bus line values.
REQ-011 t_bus_free_i  in  TimerWidth  bus-free time, in clk_i cycles.
REQ-012 gnt_o  out  NumEngines  one-hot grant.
REQ-013 ctrl_scl_o / ctrl_sda_o  out  1 each  drive to the PHY.
REQ-014 phy_sel_od_pp_o  out  1  PHY drive mode.
REQ-015 active_idx_o  out  IdxWidth  index of the granted engine.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 abort_o  out  1  one-cycle pulse when a granted engine drops req_i without sending done_i.

Function
REQ-018 The block SHALL implement the states IDLE, WAIT_FREE, GRANTED and RELEASE.
REQ-019 IDLE: when enable_i is high and any req_i bit is high, the block SHALL latch the round-robin winner, clear the timer and enter WAIT_FREE on the next edge.
REQ-020 Round-robin: the search SHALL start at pointer ptr and wrap modulo NumEngines; ptr SHALL become winner+1 (with wrap) when the block enters RELEASE.
REQ-021 WAIT_FREE: the timer SHALL increment (saturating at all-ones) while bus_scl_i and bus_sda_i are both 1, and SHALL clear when either line is 0.
REQ-022 WAIT_FREE SHALL enter GRANTED when timer >= t_bus_free_i; t_bus_free_i = 0 grants after one cycle in WAIT_FREE.
REQ-023 WAIT_FREE SHALL return to IDLE without a grant if the winner's req_i drops.
REQ-024 Latency: a request seen in IDLE on cycle N, with the bus idle and t_bus_free_i = T, SHALL produce gnt_o on cycle N+2+T.
REQ-025 GRANTED: gnt_o[winner] = 1, and ctrl_scl_o / ctrl_sda_o / phy_sel_od_pp_o SHALL follow the winner's inputs with one register stage.
REQ-026 Inputs from non-granted engines SHALL be ignored.
REQ-027 GRANTED SHALL go to RELEASE on done_i[winner]; done_i from other engines SHALL be ignored.
REQ-028 GRANTED SHALL go to RELEASE with abort_o pulsed when req_i[winner] drops without done_i; if both occur in the same cycle, done_i wins and there is no abort.
REQ-029 Deassertion of enable_i while in GRANTED SHALL NOT revoke the grant; it SHALL only block new grants from IDLE.
REQ-030 RELEASE SHALL last exactly one cycle, with gnt_o = 0, SCL = SDA = 1 and open-drain mode, then go to IDLE.
REQ-031 In IDLE and WAIT_FREE the block SHALL drive gnt_o = 0, ctrl_scl_o = 1, ctrl_sda_o = 1 and phy_sel_od_pp_o = 0.
REQ-032 At most one gnt_o bit SHALL be high on any cycle, and a grant SHALL never be asserted in the same cycle as RELEASE.

Reset
REQ-033 rst_i high at a clock edge SHALL force state IDLE, ptr = 0, timer = 0, gnt_o = 0, ctrl_scl_o = 1, ctrl_sda_o = 1, phy_sel_od_pp_o = 0, active_idx_o = 0, busy_o = 0 and abort_o = 0.
REQ-034 Reset mid-grant SHALL drop gnt_o on the following cycle, with no RELEASE state and no abort_o pulse.

Structure
REQ-035 The state enum arb_state_e and the default bus-free constant SHALL live in controller_pkg.
REQ-036 The round-robin winner search SHALL be a separate combinational sub-module, ctrl_rr_pick (req, ptr -> winner index and valid).
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 NumEngines = 2, T = 3, bus idle, req_i = 01 at cycle 0 -> gnt_o = 01 at cycle 5; done_i[0] -> RELEASE for one cycle with SCL = SDA = 1, then IDLE.
REQ-039 req_i = 11 held, each grant ended by done_i -> grants alternate 01, 10, 01; active_idx_o alternates 0, 1, 0.
REQ-040 T = 10, SDA pulled low at timer = 6 -> timer clears; grant arrives 11 cycles after SDA returns high.
REQ-041 NumEngines = 4, engine 2 granted with eng_sel_od_pp_i[2] = 1 and eng_scl_i[2] toggling -> PHY outputs follow one cycle later; toggling on engine 1 has no effect.
REQ-042 Granted engine drops req_i without done_i -> one-cycle abort_o, then RELEASE; done_i and req_i drop in the same cycle -> no abort_o.
REQ-043 rst_i asserted in GRANTED -> all outputs at reset values on the next cycle; a subsequent request restarts from ptr = 0.
